// File: rtl/hex_scan_ctrl_if.sv
// Digit write port of the seven-segment scan controller.
// wr_valid : requester holds a write until it sees wr_ready
// wr_ready : controller can take a write this cycle
// wr_addr  : digit index, 0 = rightmost
// wr_data  : 4-bit hex value for that digit
interface hex_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/hex_scan_ctrl.sv
// Round-robin scan controller for an 8-digit shared seven-segment display.
// Each digit slot is GUARD_CYCLES of all-anodes-off, one LOAD cycle that
// latches the decoded segments, then SHOW_CYCLES with that digit's anode on.
// Optional blink support is compiled in with `define HEX_SCAN_BLINK_EN.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr          : digit write port (slave side of hex_scan_ctrl_if)
//   digit_en    : per-digit enable, 0 keeps that anode dark
//   blink_mask  : per-digit blink select (blink build only)
//   hex         : active-low segments {g,f,e,d,c,b,a}
//   hex_on      : active-low anodes
//   frame_tick  : one-cycle pulse on the first cycle of each frame
module hex_scan_ctrl #(
    parameter int unsigned SHOW_CYCLES  = 100000,
    parameter int unsigned GUARD_CYCLES = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_scan_ctrl_if.slave        wr,
    input  logic [7:0]            digit_en,
    input  logic [7:0]            blink_mask,
    output logic [6:0]            hex,
    output logic [7:0]            hex_on,
    output logic                  frame_tick
);
    localparam int unsigned CNT_MAX = (SHOW_CYCLES > GUARD_CYCLES) ? SHOW_CYCLES : GUARD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        LOAD  = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0][3:0]  digit_q;
    logic [6:0]       hex_d;
    logic [7:0]       hex_on_d;
    logic             wr_ready_d;
    logic             tick_d;
    logic             hide_c;

    // Active-low hex-to-segment decode.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b0000011;
            4'hC:    seg_decode = 7'b1000110;
            4'hD:    seg_decode = 7'b0100001;
            4'hE:    seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    // Next-state, slot counter, digit index and segment latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        hex_d   = hex;
        tick_d  = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                state_d = SHOW;
                cnt_d   = '0;
                hex_d   = seg_decode(digit_q[idx_q]);
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    tick_d  = (idx_q == 3'd7);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef HEX_SCAN_BLINK_EN
    localparam int unsigned FRM_W = $clog2(BLINK_FRAMES + 1);
    logic [FRM_W-1:0] frm_q;
    logic             phase_q;

    // Blink phase flips every BLINK_FRAMES frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick_d) begin
            if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                frm_q <= frm_q + FRM_W'(1);
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
`endif

    // Anode and ready values for the upcoming cycle; registered below.
    always_comb begin
        hide_c = 1'b0;
`ifdef HEX_SCAN_BLINK_EN
        hide_c = blink_mask[idx_d] & phase_q;
`endif
        hex_on_d = 8'hFF;
        if ((state_d == SHOW) && digit_en[idx_d] && !hide_c) begin
            hex_on_d = ~(8'b1 << idx_d);
        end
        wr_ready_d = (state_d != LOAD);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            hex         <= 7'h7F;
            hex_on      <= 8'hFF;
            wr.wr_ready <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hex         <= hex_d;
            hex_on      <= hex_on_d;
            wr.wr_ready <= wr_ready_d;
            frame_tick  <= tick_d;
        end
    end

    // Digit storage; LOAD never overlaps a write since ready is low there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else if (wr.wr_valid && wr.wr_ready) begin
            digit_q[wr.wr_addr] <= wr.wr_data;
        end
    end
endmodule
